// File: rtl/chan_pkg.sv
// Shared definitions for the flash-channel arbiter: FSM encoding and parameter defaults.
package chan_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    TURN = 3'd1,
    CMD  = 3'd2,
    XFER = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int NUM_REQ_DEF = 4;
  localparam int LEN_W_DEF   = 8;

endpackage

// File: rtl/chan_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     win_oh,
  output logic [IDX_W-1:0] win_idx,
  output logic             any
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = IDX_W'((32'(ptr) + off) % N);
      if (!any && req[idx]) begin
        any         = 1'b1;
        win_idx     = idx;
        win_oh[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/chan_arbiter.sv
// Round-robin owner of the flash-channel command port: grant, issue command,
// count data beats, pulse done to the owner.
module chan_arbiter
  import chan_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int LEN_W   = LEN_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       req_wr,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic                     cmd_wr,
  output logic [LEN_W-1:0]         cmd_len,
  input  logic                     beat,
  output logic                     busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic               last_wr;
  logic               wr_r;
  logic [LEN_W-1:0]   len_r;
  logic [LEN_W-1:0]   cnt;
  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [LEN_W-1:0]   len_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_len
    assign len_arr[g] = req_len[g*LEN_W +: LEN_W];
  end

  rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  // Command fields come straight from the latches, which only change in IDLE,
  // so they are stable for the whole time cmd_valid is high.
  assign cmd_wr  = wr_r;
  assign cmd_len = len_r;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      last_wr   <= 1'b0;
      wr_r      <= 1'b0;
      len_r     <= '0;
      cnt       <= '0;
      gnt       <= '0;
      done      <= '0;
      cmd_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            gnt   <= pick_oh;
            wr_r  <= req_wr[pick_idx];
            len_r <= len_arr[pick_idx];
            cnt   <= '0;
            ptr   <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
            if (req_wr[pick_idx] != last_wr) begin
              state <= TURN;
            end else begin
              state     <= CMD;
              cmd_valid <= 1'b1;
              last_wr   <= req_wr[pick_idx];
            end
          end
        end
        TURN: begin
          state     <= CMD;
          cmd_valid <= 1'b1;
          last_wr   <= wr_r;
        end
        CMD: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            if (len_r == '0) begin
              state <= DONE;
              done  <= gnt;
            end else begin
              state <= XFER;
            end
          end
        end
        XFER: begin
          if (beat) begin
            cnt <= cnt + 1'b1;
            if (cnt == len_r - 1'b1) begin
              state <= DONE;
              done  <= gnt;
            end
          end
        end
        DONE: begin
          done  <= '0;
          gnt   <= '0;
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          gnt       <= '0;
          done      <= '0;
          cmd_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chan_arbiter.sv
// Directed bench for chan_arbiter: grant timing, round-robin order, turnaround,
// zero-length commands, back-pressure and mid-transfer reset.
module tb_chan_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, req_wr, gnt, done;
  logic [31:0] req_len;
  logic        cmd_valid, cmd_ready, cmd_wr, beat, busy;
  logic [7:0]  cmd_len;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  chan_arbiter #(.NUM_REQ(4), .LEN_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_wr    (req_wr),
    .req_len   (req_len),
    .gnt       (gnt),
    .done      (done),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_wr    (cmd_wr),
    .cmd_len   (cmd_len),
    .beat      (beat),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then stable until the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; req = '0; req_wr = '0; req_len = '0; cmd_ready = 1'b0; beat = 1'b0;
    #1;
    do_reset();
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_wr", cmd_wr, 0);
    chk("rst_cmd_len", cmd_len, 0);
    chk("rst_busy", busy, 0);

    // Single read, len 3, beats every cycle
    req = 4'b0001; req_wr = 4'b0000; req_len = 32'h0000_0003; cmd_ready = 1'b1;
    step();
    chk("t1_gnt", gnt, 4'b0001);
    chk("t1_cmd_valid", cmd_valid, 1);
    chk("t1_cmd_len", cmd_len, 3);
    chk("t1_busy", busy, 1);
    beat = 1'b1;
    step();
    chk("t1_hs_valid_low", cmd_valid, 0);
    chk("t1_beat_done0", done, 0);
    step();
    chk("t1_beat_done1", done, 0);
    step();
    chk("t1_beat_done2", done, 0);
    step();
    chk("t1_done", done, 4'b0001);
    chk("t1_done_gnt", gnt, 4'b0001);
    beat = 1'b0; req = '0;
    step();
    chk("t1_done_once", done, 0);
    chk("t1_gnt_drop", gnt, 0);
    chk("t1_idle", busy, 0);

    // Round-robin: all requesting reads, len 1
    do_reset();
    req = 4'b1111; req_wr = 4'b0000; req_len = 32'h0101_0101; cmd_ready = 1'b1; beat = 1'b1;
    for (int t = 0; t < 5; t++) begin
      step();
      chk($sformatf("rr%0d_gnt", t), gnt, 32'(4'b0001 << (t % 4)));
      step();
      step();
      chk($sformatf("rr%0d_done", t), done, 32'(4'b0001 << (t % 4)));
      step();
      chk($sformatf("rr%0d_idle_gap", t), gnt, 0);
    end
    req = '0;
    step();

    // Read by 0 then write by 1: one turnaround cycle
    do_reset();
    req = 4'b0011; req_wr = 4'b0010; req_len = 32'h0000_0101; cmd_ready = 1'b1; beat = 1'b1;
    step();
    chk("ta_rd_gnt", gnt, 4'b0001);
    chk("ta_rd_valid", cmd_valid, 1);
    step();
    step();
    chk("ta_rd_done", done, 4'b0001);
    req = 4'b0010;
    step();
    chk("ta_idle", gnt, 0);
    step();
    chk("ta_turn_gnt", gnt, 4'b0010);
    chk("ta_turn_valid", cmd_valid, 0);
    step();
    chk("ta_wr_valid", cmd_valid, 1);
    chk("ta_wr_dir", cmd_wr, 1);
    step();
    step();
    chk("ta_wr_done", done, 4'b0010);
    req = '0;
    step();

    // Zero-length command with stray beats in IDLE/CMD
    do_reset();
    req = 4'b0100; req_wr = 4'b0000; req_len = 32'h0000_0000; cmd_ready = 1'b0; beat = 1'b1;
    step();
    chk("z_gnt", gnt, 4'b0100);
    chk("z_cmd_len", cmd_len, 0);
    step();
    chk("z_hold_valid", cmd_valid, 1);
    chk("z_no_done", done, 0);
    cmd_ready = 1'b1;
    step();
    chk("z_done", done, 4'b0100);
    chk("z_valid_low", cmd_valid, 0);
    req = '0;
    step();
    chk("z_idle_gnt", gnt, 0);
    chk("z_done_once", done, 0);

    // Back-pressure on a write, then req dropped during XFER
    req = 4'b0100; req_wr = 4'b0100; req_len = 32'h0004_0000; cmd_ready = 1'b0; beat = 1'b0;
    step();
    chk("bp_turn_gnt", gnt, 4'b0100);
    chk("bp_turn_valid", cmd_valid, 0);
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("bp%0d_valid", c), cmd_valid, 1);
      chk($sformatf("bp%0d_wr", c), cmd_wr, 1);
      chk($sformatf("bp%0d_len", c), cmd_len, 4);
      req_len = 32'h0009_0000;
    end
    cmd_ready = 1'b1;
    step();
    chk("bp_xfer_valid", cmd_valid, 0);
    req = '0; beat = 1'b1;
    for (int b = 0; b < 3; b++) begin
      step();
      chk($sformatf("bp_beat%0d_done", b), done, 0);
    end
    step();
    chk("bp_done_after_drop", done, 4'b0100);
    beat = 1'b0;
    step();
    chk("bp_gnt_drop", gnt, 0);

    // Reset during a 200-beat read by engine 1
    req = 4'b0010; req_wr = 4'b0000; req_len = 32'h0000_C800; cmd_ready = 1'b1; beat = 1'b0;
    step();
    chk("mr_turn_gnt", gnt, 4'b0010);
    step();
    chk("mr_cmd_len", cmd_len, 200);
    step();
    beat = 1'b1;
    for (int b = 0; b < 10; b++) step();
    chk("mr_mid_gnt", gnt, 4'b0010);
    rst = 1'b1;
    step();
    chk("mr_gnt", gnt, 0);
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_valid", cmd_valid, 0);
    rst = 1'b0; req = 4'b1111; req_len = 32'h0101_0101; beat = 1'b0;
    step();
    chk("mr_next_gnt", gnt, 4'b0001);
    beat = 1'b1;
    step();
    step();
    chk("mr_next_done", done, 4'b0001);
    req = '0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
